// File: rtl/regfile_pkg.sv
// Shared types and constants for the 8x16 register file write-back path.
package regfile_pkg;

  localparam int unsigned NUM_REGS       = 8;
  localparam int unsigned ADDR_W         = 3;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned FIRST_WRITABLE = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push / dual-pop in-order FIFO of write-back entries.
// Pushes land at wr_ptr then wr_ptr+1; pops retire head then head+1.
module wb_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [1:0]                         push_cnt_i,
  input  regfile_pkg::wb_entry_t             push0_i,
  input  regfile_pkg::wb_entry_t             push1_i,
  input  logic [1:0]                         pop_cnt_i,
  output logic [$clog2(DEPTH):0]             count_o,
  output regfile_pkg::wb_entry_t             head_o,
  output regfile_pkg::wb_entry_t             head1_o,
  output regfile_pkg::wb_entry_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]                   valid_o
);
  import regfile_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr1, rd_ptr1;
  logic [CW-1:0]           count_q, count_d;
  wb_entry_t [DEPTH-1:0]   mem_q, mem_d;
  logic [DEPTH-1:0]        vld_q, vld_d;

  assign wr_ptr1   = wr_ptr_q + PW'(1);
  assign rd_ptr1   = rd_ptr_q + PW'(1);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign head1_o   = mem_q[rd_ptr1];
  assign entries_o = mem_q;
  assign valid_o   = vld_q;

  // Next-state storage, valid bits, pointers and occupancy.
  // Push slots are always free (caller limits pushes to free space), so
  // clearing popped slots before setting pushed ones cannot collide.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    if (pop_cnt_i >= 2'd1) vld_d[rd_ptr_q] = 1'b0;
    if (pop_cnt_i == 2'd2) vld_d[rd_ptr1]  = 1'b0;
    if (push_cnt_i >= 2'd1) begin
      mem_d[wr_ptr_q] = push0_i;
      vld_d[wr_ptr_q] = 1'b1;
    end
    if (push_cnt_i == 2'd2) begin
      mem_d[wr_ptr1] = push1_i;
      vld_d[wr_ptr1] = 1'b1;
    end
    wr_ptr_d = wr_ptr_q + PW'(push_cnt_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_cnt_i);
    count_d  = count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: buffers up to two execute results per cycle and
// drains them onto the register file's two write ports, exporting a
// pending-destination scoreboard for RAW stalls in decode.
module regfile_wb_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Res0Valid,
  input  logic [ADDR_W-1:0] Res0Dest,
  input  logic [DATA_W-1:0] Res0Data,
  output logic              Res0Ready,
  input  logic              Res1Valid,
  input  logic [ADDR_W-1:0] Res1Dest,
  input  logic [DATA_W-1:0] Res1Data,
  output logic              Res1Ready,
  input  logic              PortAFree,
  output logic [ADDR_W-1:0] DestReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              reg_Write,
  output logic [ADDR_W-1:0] Wr1Addr,
  output logic [DATA_W-1:0] WriteData1,
  output logic              reg_Write1,
  output logic [7:0]        Pending,
  output logic              DropErr
);
  import regfile_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]         count;
  wb_entry_t             head, head1;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;

  logic                  acc0, acc1, keep0, keep1;
  logic [1:0]            push_cnt, pop_cnt;
  wb_entry_t             e0, e1, push0, push1;
  logic                  wr0_d, wr1_d, drop_d;

  logic [ADDR_W-1:0]     DestReg_q, Wr1Addr_q;
  logic [DATA_W-1:0]     WriteData_q, WriteData1_q;
  logic                  reg_Write_q, reg_Write1_q, DropErr_q;
  logic [7:0]            pend;

  // Ready depends only on start-of-cycle occupancy, never on this cycle's pops.
  assign Res0Ready = (count < CW'(DEPTH));
  assign Res1Ready = (count <= CW'(DEPTH - 2));

  assign acc0  = Res0Valid & Res0Ready;
  assign acc1  = Res1Valid & Res1Ready;
  assign keep0 = acc0 && (Res0Dest >= ADDR_W'(FIRST_WRITABLE));
  assign keep1 = acc1 && (Res1Dest >= ADDR_W'(FIRST_WRITABLE));
  assign e0    = '{dest: Res0Dest, data: Res0Data};
  assign e1    = '{dest: Res1Dest, data: Res1Data};

  // Compact surviving results so a lone channel-1 result takes the first slot.
  always_comb begin
    push0    = keep0 ? e0 : e1;
    push1    = e1;
    push_cnt = {1'b0, keep0} + {1'b0, keep1};
    drop_d   = (acc0 && !keep0) || (acc1 && !keep1);
  end

  // Drain decision: head to port 0, head+1 to port 1 when port A is free and
  // the two destinations differ (same-dest pairs serialise so the younger wins).
  always_comb begin
    wr0_d   = (count >= CW'(1));
    wr1_d   = (count >= CW'(2)) && PortAFree && (head1.dest != head.dest);
    pop_cnt = wr1_d ? 2'd2 : (wr0_d ? 2'd1 : 2'd0);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .push_cnt_i (push_cnt),
    .push0_i    (push0),
    .push1_i    (push1),
    .pop_cnt_i  (pop_cnt),
    .count_o    (count),
    .head_o     (head),
    .head1_o    (head1),
    .entries_o  (entries),
    .valid_o    (valid)
  );

  // Output staging: enables reload every cycle, address/data hold when idle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      reg_Write_q  <= 1'b0;
      reg_Write1_q <= 1'b0;
      DestReg_q    <= '0;
      WriteData_q  <= '0;
      Wr1Addr_q    <= '0;
      WriteData1_q <= '0;
      DropErr_q    <= 1'b0;
    end else begin
      reg_Write_q  <= wr0_d;
      reg_Write1_q <= wr1_d;
      DropErr_q    <= drop_d;
      if (wr0_d) begin
        DestReg_q   <= head.dest;
        WriteData_q <= head.data;
      end
      if (wr1_d) begin
        Wr1Addr_q    <= head1.dest;
        WriteData1_q <= head1.data;
      end
    end
  end

  // Scoreboard: any queued entry or staged write marks its destination busy.
  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i]) pend[entries[i].dest] = 1'b1;
    end
    if (reg_Write_q)  pend[DestReg_q] = 1'b1;
    if (reg_Write1_q) pend[Wr1Addr_q] = 1'b1;
    pend[FIRST_WRITABLE-1:0] = '0;
  end

  assign DestReg    = DestReg_q;
  assign WriteData  = WriteData_q;
  assign reg_Write  = reg_Write_q;
  assign Wr1Addr    = Wr1Addr_q;
  assign WriteData1 = WriteData1_q;
  assign reg_Write1 = reg_Write1_q;
  assign Pending    = pend;
  assign DropErr    = DropErr_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with hand-computed expectations.
module tb_regfile_wb_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Res0Valid, Res1Valid, PortAFree;
  logic [2:0]  Res0Dest, Res1Dest;
  logic [15:0] Res0Data, Res1Data;
  logic        Res0Ready, Res1Ready;
  logic [2:0]  DestReg, Wr1Addr;
  logic [15:0] WriteData, WriteData1;
  logic        reg_Write, reg_Write1, DropErr;
  logic [7:0]  Pending;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_ctrl #(.DEPTH(4), .DATA_W(16), .ADDR_W(3)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Res0Valid  (Res0Valid),
    .Res0Dest   (Res0Dest),
    .Res0Data   (Res0Data),
    .Res0Ready  (Res0Ready),
    .Res1Valid  (Res1Valid),
    .Res1Dest   (Res1Dest),
    .Res1Data   (Res1Data),
    .Res1Ready  (Res1Ready),
    .PortAFree  (PortAFree),
    .DestReg    (DestReg),
    .WriteData  (WriteData),
    .reg_Write  (reg_Write),
    .Wr1Addr    (Wr1Addr),
    .WriteData1 (WriteData1),
    .reg_Write1 (reg_Write1),
    .Pending    (Pending),
    .DropErr    (DropErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [2:0] d0, input logic [15:0] x0,
                       input logic v1, input logic [2:0] d1, input logic [15:0] x1);
    Res0Valid = v0; Res0Dest = d0; Res0Data = x0;
    Res1Valid = v1; Res1Dest = d1; Res1Data = x1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  // Advance through one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0;
    PortAFree = 1'b1;
    idle();
    #12;
    check("rst_wr0",   {31'b0, reg_Write},  32'h0);
    check("rst_wr1",   {31'b0, reg_Write1}, 32'h0);
    check("rst_dest",  {29'b0, DestReg},    32'h0);
    check("rst_data",  {16'b0, WriteData},  32'h0);
    check("rst_addr1", {29'b0, Wr1Addr},    32'h0);
    check("rst_data1", {16'b0, WriteData1}, 32'h0);
    check("rst_pend",  {24'b0, Pending},    32'h0);
    check("rst_drop",  {31'b0, DropErr},    32'h0);
    check("rst_rdy0",  {31'b0, Res0Ready},  32'h1);
    check("rst_rdy1",  {31'b0, Res1Ready},  32'h1);
    Rst_n = 1'b1;

    // Single result: latency and pending window.
    drive(1'b1, 3'd5, 16'hABCD, 1'b0, 3'd0, 16'h0);
    step(); idle();
    check("s1_wr0",  {31'b0, reg_Write}, 32'h0);
    check("s1_pend", {24'b0, Pending},   32'h20);
    step();
    check("s2_wr0",  {31'b0, reg_Write},  32'h1);
    check("s2_dest", {29'b0, DestReg},    32'h5);
    check("s2_data", {16'b0, WriteData},  32'hABCD);
    check("s2_wr1",  {31'b0, reg_Write1}, 32'h0);
    check("s2_pend", {24'b0, Pending},    32'h20);
    step();
    check("s3_wr0",  {31'b0, reg_Write}, 32'h0);
    check("s3_pend", {24'b0, Pending},   32'h0);
    check("s3_hold", {29'b0, DestReg},   32'h5);

    // Dual drain to both ports.
    drive(1'b1, 3'd6, 16'h0011, 1'b1, 3'd7, 16'h0022);
    step(); idle();
    check("d1_pend", {24'b0, Pending},   32'hC0);
    check("d1_wr0",  {31'b0, reg_Write}, 32'h0);
    step();
    check("d2_wr0",   {31'b0, reg_Write},  32'h1);
    check("d2_dest",  {29'b0, DestReg},    32'h6);
    check("d2_data",  {16'b0, WriteData},  32'h0011);
    check("d2_wr1",   {31'b0, reg_Write1}, 32'h1);
    check("d2_addr1", {29'b0, Wr1Addr},    32'h7);
    check("d2_data1", {16'b0, WriteData1}, 32'h0022);
    step();
    check("d3_wr0",  {31'b0, reg_Write},  32'h0);
    check("d3_wr1",  {31'b0, reg_Write1}, 32'h0);
    check("d3_pend", {24'b0, Pending},    32'h0);

    // Same destination pair serialises.
    drive(1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002);
    step(); idle();
    check("sd1_pend", {24'b0, Pending}, 32'h20);
    step();
    check("sd2_wr0",  {31'b0, reg_Write},  32'h1);
    check("sd2_data", {16'b0, WriteData},  32'h0001);
    check("sd2_wr1",  {31'b0, reg_Write1}, 32'h0);
    check("sd2_pend", {24'b0, Pending},    32'h20);
    step();
    check("sd3_wr0",  {31'b0, reg_Write},  32'h1);
    check("sd3_dest", {29'b0, DestReg},    32'h5);
    check("sd3_data", {16'b0, WriteData},  32'h0002);
    check("sd3_wr1",  {31'b0, reg_Write1}, 32'h0);
    step();
    check("sd4_wr0", {31'b0, reg_Write}, 32'h0);

    // Read-only destination dropped.
    drive(1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 16'h0);
    step(); idle();
    check("dr1_drop", {31'b0, DropErr}, 32'h1);
    check("dr1_pend", {24'b0, Pending}, 32'h0);
    step();
    check("dr2_drop", {31'b0, DropErr},   32'h0);
    check("dr2_wr0",  {31'b0, reg_Write}, 32'h0);
    // Two drops in one cycle give one pulse.
    drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd3, 16'h3333);
    step(); idle();
    check("dd1_drop", {31'b0, DropErr}, 32'h1);
    step();
    check("dd2_drop", {31'b0, DropErr},   32'h0);
    check("dd2_wr0",  {31'b0, reg_Write}, 32'h0);
    // Channel 0 dropped, channel 1 kept and placed at the head.
    drive(1'b1, 3'd2, 16'h2222, 1'b1, 3'd4, 16'h0044);
    step(); idle();
    check("mx1_drop", {31'b0, DropErr}, 32'h1);
    check("mx1_pend", {24'b0, Pending}, 32'h10);
    step();
    check("mx2_wr0",  {31'b0, reg_Write}, 32'h1);
    check("mx2_dest", {29'b0, DestReg},   32'h4);
    check("mx2_data", {16'b0, WriteData}, 32'h0044);
    check("mx2_drop", {31'b0, DropErr},   32'h0);
    step();
    check("mx3_wr0", {31'b0, reg_Write}, 32'h0);

    // Fill with PortAFree=0: single drain, backpressure on channel 1.
    PortAFree = 1'b0;
    drive(1'b1, 3'd4, 16'h00A0, 1'b1, 3'd5, 16'h00A1);
    step();
    check("f1_rdy0", {31'b0, Res0Ready}, 32'h1);
    check("f1_rdy1", {31'b0, Res1Ready}, 32'h1);
    check("f1_wr0",  {31'b0, reg_Write}, 32'h0);
    drive(1'b1, 3'd6, 16'h00A2, 1'b1, 3'd7, 16'h00A3);
    step();
    check("f2_rdy0", {31'b0, Res0Ready},  32'h1);
    check("f2_rdy1", {31'b0, Res1Ready},  32'h0);
    check("f2_dest", {29'b0, DestReg},    32'h4);
    check("f2_data", {16'b0, WriteData},  32'h00A0);
    check("f2_wr1",  {31'b0, reg_Write1}, 32'h0);
    check("f2_pend", {24'b0, Pending},    32'hF0);
    drive(1'b1, 3'd4, 16'h00A4, 1'b1, 3'd5, 16'h00A5);
    step(); idle();
    check("f3_rdy1", {31'b0, Res1Ready},  32'h0);
    check("f3_data", {16'b0, WriteData},  32'h00A1);
    check("f3_wr1",  {31'b0, reg_Write1}, 32'h0);
    step();
    check("f4_rdy1", {31'b0, Res1Ready}, 32'h1);
    check("f4_data", {16'b0, WriteData}, 32'h00A2);
    step();
    check("f5_data", {16'b0, WriteData}, 32'h00A3);
    step();
    check("f6_wr0",  {31'b0, reg_Write}, 32'h1);
    check("f6_data", {16'b0, WriteData}, 32'h00A4);
    step();
    check("f7_wr0",  {31'b0, reg_Write}, 32'h0);
    check("f7_pend", {24'b0, Pending},   32'h0);
    step();
    check("f8_wr0",  {31'b0, reg_Write}, 32'h0);

    // Asynchronous reset with writes queued and staged.
    drive(1'b1, 3'd4, 16'h00B0, 1'b1, 3'd5, 16'h00B1);
    step();
    drive(1'b1, 3'd6, 16'h00B2, 1'b0, 3'd0, 16'h0);
    step(); idle();
    check("ar0_wr0", {31'b0, reg_Write}, 32'h1);
    #2 Rst_n = 1'b0;
    #1;
    check("ar1_wr0",  {31'b0, reg_Write},  32'h0);
    check("ar1_wr1",  {31'b0, reg_Write1}, 32'h0);
    check("ar1_pend", {24'b0, Pending},    32'h0);
    check("ar1_rdy1", {31'b0, Res1Ready},  32'h1);
    #3 Rst_n = 1'b1;
    step();
    check("ar2_wr0",  {31'b0, reg_Write}, 32'h0);
    check("ar2_pend", {24'b0, Pending},   32'h0);
    step();
    check("ar3_wr0",  {31'b0, reg_Write}, 32'h0);
    check("ar3_pend", {24'b0, Pending},   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
